// File: rtl/rtc_seq_pkg.sv
// Shared definitions for the RTC bus-cycle phase sequencer and the bus signal decoder.
package rtc_seq_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

  localparam logic MODE_WR = 1'b0;
  localparam logic MODE_RD = 1'b1;

  // Phase indices as seen by the bus signal decoder.
  localparam int PH_ADDR_SETUP  = 0;
  localparam int PH_ADDR_HOLD   = 1;
  localparam int PH_CS_SETUP    = 2;
  localparam int PH_CMD_SETUP   = 3;
  localparam int PH_STB_ASSERT  = 4;
  localparam int PH_STB_WIDTH   = 5;
  localparam int PH_DATA_VALID  = 6;
  localparam int PH_STB_RELEASE = 7;
  localparam int PH_DATA_HOLD   = 8;
  localparam int PH_CS_HOLD     = 9;
  localparam int PH_TURNAROUND  = 10;
  localparam int PH_RECOVERY    = 11;

  // Packed phase 11 first, phase 0 last; phase p sits at [p*6 +: 6].
  localparam logic [71:0] DUR_WR_DEFAULT = {
    6'd10, 6'd50, 6'd10, 6'd10, 6'd20, 6'd60,
    6'd20, 6'd10, 6'd10, 6'd20, 6'd20, 6'd20
  };
  localparam logic [71:0] DUR_RD_DEFAULT = DUR_WR_DEFAULT;

endpackage

// File: rtl/rtc_dwell_mux.sv
// Selects the dwell count of the current phase from the write or read profile.
module rtc_dwell_mux
  import rtc_seq_pkg::*;
#(
  parameter int NUM_PHASES = 12,
  parameter int PHASE_W    = 4,
  parameter int CNT_W      = 6
) (
  input  logic                          sel_mode,
  input  logic [PHASE_W-1:0]            phase,
  input  logic [NUM_PHASES*CNT_W-1:0]   dur_wr,
  input  logic [NUM_PHASES*CNT_W-1:0]   dur_rd,
  output logic [CNT_W-1:0]              dwell
);

  logic [NUM_PHASES*CNT_W-1:0] prof;

  assign prof  = (sel_mode == MODE_RD) ? dur_rd : dur_wr;
  assign dwell = prof[phase*CNT_W +: CNT_W];

endmodule

// File: rtl/rtc_phase_sequencer.sv
// Steps a phase index through NUM_PHASES phases, each held for a profile-selected
// number of clocks, with start/busy/done handshake, abort and continuous repeat.
module rtc_phase_sequencer
  import rtc_seq_pkg::*;
#(
  parameter int NUM_PHASES = 12,
  parameter int PHASE_W    = 4,
  parameter int CNT_W      = 6,
  parameter     DUR_WR     = DUR_WR_DEFAULT,
  parameter     DUR_RD     = DUR_RD_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic               abort,
  input  logic               continuous,
  output logic               busy,
  output logic [PHASE_W-1:0] phase,
  output logic               phase_stb,
  output logic               done,
  output logic               cur_mode,
  output seq_state_e         state_dbg
);

  localparam int PROF_W = NUM_PHASES * CNT_W;
  localparam logic [PROF_W-1:0]  WR_PROF = PROF_W'(DUR_WR);
  localparam logic [PROF_W-1:0]  RD_PROF = PROF_W'(DUR_RD);
  localparam logic [PHASE_W-1:0] LAST_PH = PHASE_W'(NUM_PHASES - 1);

  if (NUM_PHASES < 2 || NUM_PHASES > 16) begin : g_bad_num
    $error("rtc_phase_sequencer: NUM_PHASES must be 2..16");
  end
  if ((1 << PHASE_W) < NUM_PHASES) begin : g_bad_phase_w
    $error("rtc_phase_sequencer: PHASE_W too narrow for NUM_PHASES");
  end
  if ($bits(DUR_WR) > PROF_W) begin : g_wr_wide
    if (|(DUR_WR >> PROF_W)) begin : g_wr_err
      $error("rtc_phase_sequencer: DUR_WR dwell exceeds CNT_W range");
    end
  end
  if ($bits(DUR_RD) > PROF_W) begin : g_rd_wide
    if (|(DUR_RD >> PROF_W)) begin : g_rd_err
      $error("rtc_phase_sequencer: DUR_RD dwell exceeds CNT_W range");
    end
  end

  seq_state_e         state, state_n;
  logic [PHASE_W-1:0] phase_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [CNT_W-1:0]   dwell;
  logic               mode_n, stb_n, done_n;

  rtc_dwell_mux #(
    .NUM_PHASES (NUM_PHASES),
    .PHASE_W    (PHASE_W),
    .CNT_W      (CNT_W)
  ) u_dwell_mux (
    .sel_mode (cur_mode),
    .phase    (phase),
    .dur_wr   (WR_PROF),
    .dur_rd   (RD_PROF),
    .dwell    (dwell)
  );

  // Handshake: start is accepted only in IDLE without abort; busy stays high from
  // the accept edge until the final-phase edge, where done pulses for one cycle.
  always_comb begin
    state_n = state;
    phase_n = phase;
    cnt_n   = cnt;
    mode_n  = cur_mode;
    stb_n   = 1'b0;
    done_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        phase_n = '0;
        cnt_n   = '0;
        if (start && !abort) begin
          state_n = ST_RUN;
          stb_n   = 1'b1;
          mode_n  = mode;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_n = ST_IDLE;
          phase_n = '0;
          cnt_n   = '0;
        end else if (cnt != dwell) begin
          cnt_n = cnt + CNT_W'(1);
        end else if (phase != LAST_PH) begin
          phase_n = phase + PHASE_W'(1);
          cnt_n   = '0;
          stb_n   = 1'b1;
        end else begin
          done_n  = 1'b1;
          phase_n = '0;
          cnt_n   = '0;
          if (continuous) begin
            stb_n  = 1'b1;
            mode_n = mode;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      phase     <= '0;
      cnt       <= '0;
      cur_mode  <= 1'b0;
      phase_stb <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      cnt       <= cnt_n;
      cur_mode  <= mode_n;
      phase_stb <= stb_n;
      done      <= done_n;
    end
  end

  assign busy      = (state == ST_RUN);
  assign state_dbg = state;

endmodule

// File: tb/tb_rtc_phase_sequencer.sv
// Directed bench for rtc_phase_sequencer: u0 uses the default profiles, u1 has a
// zero-dwell write phase 2 and a flat 4-cycle read profile.
module tb_rtc_phase_sequencer;
  import rtc_seq_pkg::*;

  localparam logic [71:0] WR_SHORT = {
    6'd10, 6'd50, 6'd10, 6'd10, 6'd20, 6'd60,
    6'd20, 6'd10, 6'd10, 6'd0,  6'd20, 6'd20
  };
  localparam logic [71:0] RD_FAST = {12{6'd3}};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start[2], mode[2], abort[2], cont[2];
  logic       busy[2], phase_stb[2], done[2], cur_mode[2];
  logic [3:0] phase[2];
  seq_state_e state_dbg[2];

  int n_chk = 0;
  int n_bad = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  rtc_phase_sequencer u0 (
    .clk(clk), .reset(reset), .start(start[0]), .mode(mode[0]), .abort(abort[0]),
    .continuous(cont[0]), .busy(busy[0]), .phase(phase[0]), .phase_stb(phase_stb[0]),
    .done(done[0]), .cur_mode(cur_mode[0]), .state_dbg(state_dbg[0])
  );

  rtc_phase_sequencer #(.DUR_WR(WR_SHORT), .DUR_RD(RD_FAST)) u1 (
    .clk(clk), .reset(reset), .start(start[1]), .mode(mode[1]), .abort(abort[1]),
    .continuous(cont[1]), .busy(busy[1]), .phase(phase[1]), .phase_stb(phase_stb[1]),
    .done(done[1]), .cur_mode(cur_mode[1]), .state_dbg(state_dbg[1])
  );

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_phase(input int u, input int ph, output bit ok);
    ok = 1'b0;
    for (int g = 0; g < 600; g++) begin
      if (busy[u] && phase[u] == ph && phase_stb[u]) begin
        ok = 1'b1;
        return;
      end
      step();
    end
  endtask

  // Entered on the first busy cycle; returns on the first non-busy cycle.
  task automatic measure(input int u, input int pulse_at, output int cyc,
                         output int n_done, output int n_stb, output int dur[16]);
    cyc = 0; n_done = 0; n_stb = 0;
    for (int i = 0; i < 16; i++) dur[i] = 0;
    for (int g = 0; g < 1000; g++) begin
      if (done[u]) n_done++;
      if (!busy[u]) return;
      cyc++;
      dur[phase[u]]++;
      n_stb += int'(phase_stb[u]);
      start[u] = (cyc == pulse_at);
      step();
    end
  endtask

  // ---------------- stimulus ----------------
  int exp_wr[12] = '{21, 21, 21, 11, 11, 21, 61, 21, 11, 11, 51, 11};
  int cyc, nd, ns, total, ph2, ph2_stb, any_done;
  int dur[16];
  bit ok;

  initial begin
    for (int u = 0; u < 2; u++) begin
      start[u] = 0; mode[u] = 0; abort[u] = 0; cont[u] = 0;
    end
    repeat (3) step();
    check("rst_busy", busy[0], 0);
    check("rst_phase", phase[0], 0);
    check("rst_stb", phase_stb[0], 0);
    check("rst_done", done[0], 0);
    check("rst_mode", cur_mode[0], 0);
    check("rst_state", state_dbg[0], ST_IDLE);
    reset = 0;
    step();
    check("idle_busy", busy[0], 0);

    // default write profile, full transaction
    start[0] = 1; mode[0] = MODE_WR;
    step();
    check("wr_start_busy", busy[0], 1);
    check("wr_start_phase", phase[0], 0);
    check("wr_start_stb", phase_stb[0], 1);
    check("wr_start_state", state_dbg[0], ST_RUN);
    start[0] = 0;
    measure(0, -1, cyc, nd, ns, dur);
    check("wr_len", cyc, 272);
    check("wr_done_cnt", nd, 1);
    check("wr_stb_cnt", ns, 12);
    for (int p = 0; p < 12; p++) check($sformatf("wr_dur%0d", p), dur[p], exp_wr[p]);
    check("wr_end_done", done[0], 1);
    check("wr_end_phase", phase[0], 0);
    step();
    check("wr_done_pulse", done[0], 0);

    // fast read profile, mode toggled mid-run
    start[1] = 1; mode[1] = MODE_RD;
    step();
    check("rd_cur_mode", cur_mode[1], 1);
    start[1] = 0; mode[1] = MODE_WR;
    measure(1, -1, cyc, nd, ns, dur);
    check("rd_len", cyc, 48);
    check("rd_done_cnt", nd, 1);
    for (int p = 0; p < 12; p++) check($sformatf("rd_dur%0d", p), dur[p], 4);
    check("rd_end_mode", cur_mode[1], 1);

    // start held through done: one idle cycle then a new transaction
    start[1] = 1; mode[1] = MODE_RD;
    step();
    for (int g = 0; g < 200; g++) begin
      if (done[1]) break;
      step();
    end
    check("b2b_done", done[1], 1);
    check("b2b_gap_busy", busy[1], 0);
    step();
    check("b2b_restart_busy", busy[1], 1);
    check("b2b_restart_stb", phase_stb[1], 1);
    start[1] = 0; abort[1] = 1;
    step();
    abort[1] = 0;
    check("b2b_abort_busy", busy[1], 0);

    // abort in phase 6 at cnt=30
    start[0] = 1; mode[0] = MODE_WR;
    step();
    start[0] = 0;
    wait_phase(0, 6, ok);
    check("ab_reach_ph6", ok, 1);
    repeat (30) step();
    check("ab_pre_phase", phase[0], 6);
    abort[0] = 1;
    step();
    abort[0] = 0;
    check("ab_busy", busy[0], 0);
    check("ab_phase", phase[0], 0);
    check("ab_done", done[0], 0);
    check("ab_stb", phase_stb[0], 0);
    any_done = 0;
    for (int g = 0; g < 5; g++) begin
      any_done += int'(done[0]);
      step();
    end
    check("ab_no_done", any_done, 0);
    start[0] = 1; abort[0] = 1;
    step();
    check("ab_start_busy", busy[0], 0);
    start[0] = 0; abort[0] = 0;
    step();
    check("ab_start_after", busy[0], 0);

    // continuous with mode switch during phase 9; zero-dwell phase 2
    cont[1] = 1; mode[1] = MODE_WR; start[1] = 1;
    step();
    start[1] = 0;
    total = 0; ph2 = 0; ph2_stb = 0;
    for (int g = 0; g < 600; g++) begin
      if (done[1]) break;
      if (phase[1] == 2) begin
        ph2++;
        ph2_stb += int'(phase_stb[1]);
      end
      if (phase[1] == 9) mode[1] = MODE_RD;
      total++;
      step();
    end
    check("ct_len", total, 252);
    check("ct_ph2_len", ph2, 1);
    check("ct_ph2_stb", ph2_stb, 1);
    check("ct_wrap_done", done[1], 1);
    check("ct_wrap_stb", phase_stb[1], 1);
    check("ct_wrap_busy", busy[1], 1);
    check("ct_wrap_mode", cur_mode[1], 1);
    check("ct_wrap_phase", phase[1], 0);
    cont[1] = 0;
    measure(1, -1, cyc, nd, ns, dur);
    check("ct_rd_len", cyc, 48);
    check("ct_rd_done_cnt", nd, 2);   // wrap pulse plus final completion
    check("ct_rd_dur0", dur[0], 4);
    check("ct_rd_dur11", dur[11], 4);

    // start pulsed while busy is ignored
    start[0] = 1; mode[0] = MODE_WR;
    step();
    start[0] = 0;
    measure(0, 50, cyc, nd, ns, dur);
    check("busy_start_len", cyc, 272);
    check("busy_start_done", nd, 1);
    step();
    check("busy_start_idle", busy[0], 0);

    // reset mid-phase 3 clears everything including cur_mode
    start[0] = 1; mode[0] = MODE_RD;
    step();
    start[0] = 0;
    check("rs_mode_set", cur_mode[0], 1);
    wait_phase(0, 3, ok);
    check("rs_reach_ph3", ok, 1);
    repeat (2) step();
    reset = 1;
    step();
    check("rs_busy", busy[0], 0);
    check("rs_phase", phase[0], 0);
    check("rs_stb", phase_stb[0], 0);
    check("rs_done", done[0], 0);
    check("rs_mode", cur_mode[0], 0);
    check("rs_state", state_dbg[0], ST_IDLE);
    reset = 0;
    step();

    // ---------------- final report ----------------
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
